// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: ALU op encoding, forwarding source select
// and datapath widths.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXM,
    FWD_MWB
  } fwd_sel_t;

endpackage

// File: rtl/operand_fwd.sv
// Single-operand forwarding: picks the freshest value for one source register
// from EX/MEM, MEM/WB or the value captured at decode.
module operand_fwd
  import rv32i_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] rs_addr,
  input  logic [DW-1:0] rs_data,
  input  logic          exm_reg_write,
  input  logic          exm_mem_read,
  input  logic [AW-1:0] exm_rd_addr,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [AW-1:0] mwb_rd_addr,
  input  logic [DW-1:0] mwb_result,
  output logic [DW-1:0] fwd_data
);

  fwd_sel_t sel;

  // A load sitting in EX/MEM has no data yet; the load-use bubble guarantees
  // its consumer finds it in MEM/WB one cycle later instead.
  always_comb begin
    // NOTE: default first so every path assigns sel -- no latch is inferred.
    sel = FWD_REG;
    if (exm_reg_write && !exm_mem_read && exm_rd_addr != '0 && exm_rd_addr == rs_addr)
      sel = FWD_EXM;
    else if (mwb_reg_write && mwb_rd_addr != '0 && mwb_rd_addr == rs_addr)
      sel = FWD_MWB;
  end

  always_comb begin
    unique case (sel)
      FWD_EXM: fwd_data = exm_result;
      FWD_MWB: fwd_data = mwb_result;
      default: fwd_data = rs_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, resolves
// operand forwarding and raises the load-use hazard toward fetch/decode.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [2:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              ex_valid,
  output logic [2:0]        ex_alu_op,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              load_use_stall
);

  import rv32i_pkg::*;

  logic              valid_q, valid_d;
  alu_op_t           alu_op_q, alu_op_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic              use_imm_q, use_imm_d, reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

  // Store rs2 compares only when use_imm is clear, matching decode's encoding.
  assign load_use_stall = valid_q && mem_read_q && rd_addr_q != '0 && id_valid &&
                          (rd_addr_q == id_rs1_addr ||
                           (rd_addr_q == id_rs2_addr && !id_use_imm));
  assign id_ready = !ex_stall && !load_use_stall;

  always_comb begin
    valid_d     = valid_q;
    alu_op_d    = alu_op_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ex_stall) begin
      // hold everything
    end else if (load_use_stall) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else begin
      valid_d     = id_valid;
      alu_op_d    = alu_op_t'(id_alu_op);
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      use_imm_d   = id_use_imm;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      alu_op_q    <= ADD;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  operand_fwd #(.DW(XLEN), .AW(REG_AW)) u_fwd_rs1 (
    .rs_addr(rs1_addr_q), .rs_data(rs1_data_q),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr),
    .mwb_result(mwb_result), .fwd_data(rs1_fwd)
  );

  operand_fwd #(.DW(XLEN), .AW(REG_AW)) u_fwd_rs2 (
    .rs_addr(rs2_addr_q), .rs_data(rs2_data_q),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr),
    .mwb_result(mwb_result), .fwd_data(rs2_fwd)
  );

  assign ex_valid      = valid_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_a          = rs1_fwd;
  assign ex_b          = use_imm_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_rd_addr    = rd_addr_q;
  // Side effects of a bubble must never reach later stages.
  assign ex_reg_write  = valid_q && reg_write_q;
  assign ex_mem_read   = valid_q && mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model of the stage
// checked every cycle, plus literal expectations for the key scenarios.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read;
  logic        ex_stall, flush;
  logic        exm_reg_write, exm_mem_read;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd_addr;
  logic [31:0] mwb_result;
  logic        ex_valid;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, load_use_stall;

  int checks = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_op(id_alu_op), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_stall(ex_stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently occupying EX (or nothing).
  typedef struct {
    bit        valid;
    bit [2:0]  op;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm;
    bit        use_imm, rw, mr;
  } ex_instr_t;

  ex_instr_t m;

  function automatic bit model_hazard();
    if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 1'b0;
    return (m.rd == id_rs1_addr) || (m.rd == id_rs2_addr && !id_use_imm);
  endfunction

  function automatic logic [31:0] model_operand(input bit [4:0] a, input bit [31:0] d);
    if (a == 0) return d;
    if (exm_reg_write && !exm_mem_read && exm_rd_addr == a) return exm_result;
    if (mwb_reg_write && mwb_rd_addr == a) return mwb_result;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: 0};
    end else if (flush) begin
      m.valid = 1'b0;
    end else if (ex_stall) begin
      // instruction stays in EX
    end else if (model_hazard()) begin
      m.valid = 1'b0;
    end else begin
      m = '{valid: id_valid, op: id_alu_op, rs1: id_rs1_addr, rs2: id_rs2_addr,
            rd: id_rd_addr, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm,
            use_imm: id_use_imm, rw: id_reg_write, mr: id_mem_read};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_valid", 32'(ex_valid), 32'(m.valid));
      check("m_reg_write", 32'(ex_reg_write), 32'(m.valid && m.rw));
      check("m_mem_read", 32'(ex_mem_read), 32'(m.valid && m.mr));
      check("m_load_use", 32'(load_use_stall), 32'(model_hazard()));
      check("m_id_ready", 32'(id_ready), 32'(!ex_stall && !model_hazard()));
      if (m.valid) begin
        check("m_alu_op", 32'(ex_alu_op), 32'(m.op));
        check("m_rd", 32'(ex_rd_addr), 32'(m.rd));
        check("m_a", ex_a, model_operand(m.rs1, m.d1));
        check("m_b", ex_b, m.use_imm ? m.imm : model_operand(m.rs2, m.d2));
        check("m_store", ex_store_data, model_operand(m.rs2, m.d2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [2:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                        input logic ui, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1'b1; id_alu_op = op;
    id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2; id_rs2_data = d2;
    id_imm = imm; id_use_imm = ui; id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd_addr = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd_addr = '0; mwb_result = '0;
    repeat (2) tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_alu_op", 32'(ex_alu_op), 32'd0);
    check("rst_a", ex_a, 32'd0);
    check("rst_b", ex_b, 32'd0);
    rst_n = 1'b1;
    tick();

    // Pass-through ADD x1(5) + imm 7
    set_id(3'd0, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 1'b1, 5'd2, 1'b1, 1'b0);
    tick();
    check("pass_valid", 32'(ex_valid), 32'd1);
    check("pass_a", ex_a, 32'd5);
    check("pass_b", ex_b, 32'd7);
    check("pass_op", 32'(ex_alu_op), 32'd0);

    // Forwarding priority on rs1=x3
    set_id(3'd3, 5'd3, 32'h99, 5'd0, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    ex_stall = 1'b1;
    exm_reg_write = 1'b1; exm_rd_addr = 5'd3; exm_result = 32'h10;
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd3; mwb_result = 32'h20;
    #1 check("fwd_exm", ex_a, 32'h10);
    exm_reg_write = 1'b0;
    #1 check("fwd_mwb", ex_a, 32'h20);
    exm_reg_write = 1'b1; exm_mem_read = 1'b1;
    #1 check("fwd_exm_load", ex_a, 32'h20);
    mwb_reg_write = 1'b0;
    #1 check("fwd_none", ex_a, 32'h99);
    exm_mem_read = 1'b0;
    ex_stall = 1'b0;
    set_id(3'd0, 5'd0, 32'h55, 5'd0, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    exm_rd_addr = 5'd0; mwb_rd_addr = 5'd0; mwb_reg_write = 1'b1;
    tick();
    check("fwd_x0", ex_a, 32'h55);
    exm_reg_write = 1'b0; mwb_reg_write = 1'b0;

    // Load-use: LW x4 then SUB x7 = x4 - x6
    set_id(3'd0, 5'd1, 32'h100, 5'd0, 32'd0, 32'd8, 1'b1, 5'd4, 1'b1, 1'b1);
    tick();
    check("lu_ex_load", 32'(ex_mem_read), 32'd1);
    set_id(3'd1, 5'd4, 32'd0, 5'd6, 32'd3, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1 check("lu_stall", 32'(load_use_stall), 32'd1);
    check("lu_ready", 32'(id_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    check("lu_released", 32'(load_use_stall), 32'd0);
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd4; mwb_result = 32'h1234;
    tick();
    check("lu_sub_valid", 32'(ex_valid), 32'd1);
    check("lu_sub_op", 32'(ex_alu_op), 32'd1);
    check("lu_sub_a", ex_a, 32'h1234);
    check("lu_sub_b", ex_b, 32'd3);
    mwb_reg_write = 1'b0;

    // rs2 hazard only when rs2 is a register operand
    set_id(3'd0, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd6, 1'b1, 1'b1);
    tick();
    set_id(3'd0, 5'd2, 32'd0, 5'd6, 32'd0, 32'd4, 1'b1, 5'd9, 1'b1, 1'b0);
    #1 check("lu_rs2_imm", 32'(load_use_stall), 32'd0);
    id_use_imm = 1'b0;
    #1 check("lu_rs2_reg", 32'(load_use_stall), 32'd1);
    id_valid = 1'b0;
    #1 check("lu_no_id", 32'(load_use_stall), 32'd0);
    tick();

    // Flush beats stall
    set_id(3'd4, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    flush = 1'b1; ex_stall = 1'b1;
    tick();
    check("flush_stall", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;
    set_id(3'd2, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    ex_stall = 1'b1;
    set_id(3'd3, 5'd5, 32'h77, 5'd6, 32'h88, 32'd1, 1'b1, 5'd11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_op", 32'(ex_alu_op), 32'd2);
      check("stall_a", ex_a, 32'h11);
      check("stall_b", ex_b, 32'h22);
      check("stall_rd", 32'(ex_rd_addr), 32'd10);
      check("stall_ready", 32'(id_ready), 32'd0);
    end
    ex_stall = 1'b0;

    // Store data forwarded while b carries the immediate
    set_id(3'd0, 5'd1, 32'd7, 5'd5, 32'd1, 32'h40, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    exm_reg_write = 1'b1; exm_rd_addr = 5'd5; exm_result = 32'hABCD;
    #1 check("st_b", ex_b, 32'h40);
    check("st_data", ex_store_data, 32'hABCD);
    check("st_a", ex_a, 32'd7);
    exm_reg_write = 1'b0;

    // Asynchronous reset mid-stream
    set_id(3'd4, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    check("pre_rst_rw", 32'(ex_reg_write), 32'd1);
    check("pre_rst_op", 32'(ex_alu_op), 32'd4);
    #2 rst_n = 1'b0;
    #1 check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_rw", 32'(ex_reg_write), 32'd0);
    check("arst_op", 32'(ex_alu_op), 32'd0);
    tick();
    rst_n = 1'b1; id_valid = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
